// File: rtl/id_ex_hazard_reg.sv
// ============================================================================
//  Module   : id_ex_hazard_reg
//  Purpose  : ID/EX pipeline register with valid bit, stall, flush, load-use
//             bubble insertion and a saturating bubble counter.
//             Define ID_EX_HAZARD_EN to enable built-in load-use detection.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int JUMP_W = 11,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_a_in,
    input  logic [DATA_W-1:0] data_b_in,
    input  logic [DATA_W-1:0] sign_extend_in,
    input  logic [JUMP_W-1:0] jump_dest_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  sa_in,
    input  logic [17:0]       ctrl_in,
    input  logic              valid_in,
    input  logic              uses_rs_in,
    input  logic              uses_rt_in,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic [DATA_W-1:0] data_a_out,
    output logic [DATA_W-1:0] data_b_out,
    output logic [DATA_W-1:0] sign_extend_out,
    output logic [JUMP_W-1:0] jump_dest_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  sa_out,
    output logic [17:0]       ctrl_out,
    output logic              valid_out,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam int c_MEMREAD_BIT = 4;

    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [DATA_W-1:0] r_sign_extend;
    logic [JUMP_W-1:0] r_jump_dest;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_sa;
    logic [17:0]       r_ctrl;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_count;

    logic              w_hazard;
    logic              w_bubble;
    logic              w_count_event;

`ifdef ID_EX_HAZARD_EN
    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = uses_rs_in && (rs_in == r_rt);
    assign w_rt_match = uses_rt_in && (rt_in == r_rt);
    // EX holds a load whose destination is read by the instruction in ID
    assign w_hazard   = valid_in && !flush_in && r_valid && r_ctrl[c_MEMREAD_BIT]
                        && (r_rt != '0) && (w_rs_match || w_rt_match);
`else
    logic w_unused_hazard_inputs;

    assign w_unused_hazard_inputs = uses_rs_in ^ uses_rt_in;
    assign w_hazard               = 1'b0;
`endif

    assign w_bubble      = flush_in || w_hazard || !valid_in;
    assign w_count_event = flush_in || w_hazard;

    always_ff @(negedge clock) begin
        if (reset) begin
            r_data_a       <= '0;
            r_data_b       <= '0;
            r_sign_extend  <= '0;
            r_jump_dest    <= '0;
            r_rd           <= '0;
            r_rt           <= '0;
            r_rs           <= '0;
            r_sa           <= '0;
            r_ctrl         <= '0;
            r_valid        <= 1'b0;
            r_bubble_count <= '0;
        end else if (stall_in) begin
            r_valid <= r_valid;
        end else if (w_bubble) begin
            r_data_a      <= '0;
            r_data_b      <= '0;
            r_sign_extend <= '0;
            r_jump_dest   <= '0;
            r_rd          <= '0;
            r_rt          <= '0;
            r_rs          <= '0;
            r_sa          <= '0;
            r_ctrl        <= '0;
            r_valid       <= 1'b0;
            // Counter saturates rather than wrapping
            if (w_count_event && (r_bubble_count != {CNT_W{1'b1}})) begin
                r_bubble_count <= r_bubble_count + 1'b1;
            end
        end else begin
            r_data_a      <= data_a_in;
            r_data_b      <= data_b_in;
            r_sign_extend <= sign_extend_in;
            r_jump_dest   <= jump_dest_in;
            r_rd          <= rd_in;
            r_rt          <= rt_in;
            r_rs          <= rs_in;
            r_sa          <= sa_in;
            r_ctrl        <= ctrl_in;
            r_valid       <= 1'b1;
        end
    end

    assign data_a_out      = r_data_a;
    assign data_b_out      = r_data_b;
    assign sign_extend_out = r_sign_extend;
    assign jump_dest_out   = r_jump_dest;
    assign rd_out          = r_rd;
    assign rt_out          = r_rt;
    assign rs_out          = r_rs;
    assign sa_out          = r_sa;
    assign ctrl_out        = r_ctrl;
    assign valid_out       = r_valid;
    assign hazard_stall    = w_hazard;
    assign bubble_count    = r_bubble_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
// ============================================================================
//  Module   : tb_id_ex_hazard_reg
//  Purpose  : Self-checking bench for id_ex_hazard_reg (directed + random).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_reg;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_a_in, data_b_in, sign_extend_in;
    logic [10:0] jump_dest_in;
    logic [4:0]  rd_in, rt_in, rs_in, sa_in;
    logic [17:0] ctrl_in;
    logic        valid_in, uses_rs_in, uses_rt_in, stall_in, flush_in;

    logic [31:0] data_a_out, data_b_out, sign_extend_out;
    logic [10:0] jump_dest_out;
    logic [4:0]  rd_out, rt_out, rs_out, sa_out;
    logic [17:0] ctrl_out;
    logic        valid_out, hazard_stall;
    logic [15:0] bubble_count;

    logic [31:0] s_data_a_out, s_data_b_out, s_sign_extend_out;
    logic [10:0] s_jump_dest_out;
    logic [4:0]  s_rd_out, s_rt_out, s_rs_out, s_sa_out;
    logic [17:0] s_ctrl_out;
    logic        s_valid_out, s_hazard_stall;
    logic [1:0]  s_bubble_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    id_ex_hazard_reg dut (
        .clock(clock), .reset(reset),
        .data_a_in(data_a_in), .data_b_in(data_b_in), .sign_extend_in(sign_extend_in),
        .jump_dest_in(jump_dest_in), .rd_in(rd_in), .rt_in(rt_in), .rs_in(rs_in),
        .sa_in(sa_in), .ctrl_in(ctrl_in), .valid_in(valid_in), .uses_rs_in(uses_rs_in),
        .uses_rt_in(uses_rt_in), .stall_in(stall_in), .flush_in(flush_in),
        .data_a_out(data_a_out), .data_b_out(data_b_out), .sign_extend_out(sign_extend_out),
        .jump_dest_out(jump_dest_out), .rd_out(rd_out), .rt_out(rt_out), .rs_out(rs_out),
        .sa_out(sa_out), .ctrl_out(ctrl_out), .valid_out(valid_out),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    id_ex_hazard_reg #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .data_a_in(data_a_in), .data_b_in(data_b_in), .sign_extend_in(sign_extend_in),
        .jump_dest_in(jump_dest_in), .rd_in(rd_in), .rt_in(rt_in), .rs_in(rs_in),
        .sa_in(sa_in), .ctrl_in(ctrl_in), .valid_in(valid_in), .uses_rs_in(uses_rs_in),
        .uses_rt_in(uses_rt_in), .stall_in(stall_in), .flush_in(flush_in),
        .data_a_out(s_data_a_out), .data_b_out(s_data_b_out), .sign_extend_out(s_sign_extend_out),
        .jump_dest_out(s_jump_dest_out), .rd_out(s_rd_out), .rt_out(s_rt_out), .rs_out(s_rs_out),
        .sa_out(s_sa_out), .ctrl_out(s_ctrl_out), .valid_out(s_valid_out),
        .hazard_stall(s_hazard_stall), .bubble_count(s_bubble_count)
    );

    // Reference model: contents of EX as a record, bubble events as a plain integer
    typedef struct {
        bit          valid;
        logic [31:0] a, b, se;
        logic [10:0] jd;
        logic [4:0]  rd, rt, rs, sa;
        logic [17:0] ctrl;
    } ex_t;

    ex_t m_ex;
    int  m_bubbles;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
`ifdef ID_EX_HAZARD_EN
        bit dep;
        dep = (uses_rs_in && rs_in == m_ex.rt) || (uses_rt_in && rt_in == m_ex.rt);
        return valid_in && !flush_in && m_ex.valid && m_ex.ctrl[4] && (m_ex.rt != 0) && dep;
`else
        return 1'b0;
`endif
    endfunction

    // Inputs are set just after a rising edge; one call covers one falling edge
    task automatic step();
        bit haz;
        ex_t empty;
        empty = '{default: '0};
        #1;
        haz = model_hazard();
        check_value("hazard_stall", {63'd0, hazard_stall}, {63'd0, haz});
        @(negedge clock);
        if (reset) begin
            m_ex = empty;
            m_bubbles = 0;
        end else if (stall_in) begin
            m_ex = m_ex;
        end else if (flush_in || haz || !valid_in) begin
            m_ex = empty;
            if (flush_in || haz) m_bubbles++;
        end else begin
            m_ex = '{1'b1, data_a_in, data_b_in, sign_extend_in, jump_dest_in,
                     rd_in, rt_in, rs_in, sa_in, ctrl_in};
        end
        #1;
        check_value("valid_out", {63'd0, valid_out}, {63'd0, m_ex.valid});
        check_value("ctrl_out", {46'd0, ctrl_out}, {46'd0, m_ex.ctrl});
        check_value("data_a_out", {32'd0, data_a_out}, {32'd0, m_ex.a});
        check_value("data_b_out", {32'd0, data_b_out}, {32'd0, m_ex.b});
        check_value("sign_extend_out", {32'd0, sign_extend_out}, {32'd0, m_ex.se});
        check_value("specifiers", {37'd0, jump_dest_out, rd_out, rt_out, rs_out, sa_out},
                    {37'd0, m_ex.jd, m_ex.rd, m_ex.rt, m_ex.rs, m_ex.sa});
        check_value("bubble_count", {48'd0, bubble_count},
                    (m_bubbles > 65535) ? 64'd65535 : 64'(m_bubbles));
        check_value("bubble_count_w2", {62'd0, s_bubble_count},
                    (m_bubbles > 3) ? 64'd3 : 64'(m_bubbles));
        check_value("sat_valid_out", {63'd0, s_valid_out}, {63'd0, m_ex.valid});
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic use_rs, input logic use_rt, input logic [17:0] ctrl);
        reset = 0; stall_in = 0; flush_in = 0; valid_in = 1;
        rs_in = rs; rt_in = rt; uses_rs_in = use_rs; uses_rt_in = use_rt; ctrl_in = ctrl;
        rd_in = 5'd7; sa_in = 5'd3;
        data_a_in = $urandom; data_b_in = $urandom; sign_extend_in = $urandom;
        jump_dest_in = 11'($urandom);
    endtask

    task automatic rand_inputs();
        reset          = ($urandom_range(0, 63) == 0);
        stall_in       = ($urandom_range(0, 7) == 0);
        flush_in       = ($urandom_range(0, 7) == 0);
        valid_in       = ($urandom_range(0, 5) != 0);
        uses_rs_in     = $urandom_range(0, 1);
        uses_rt_in     = $urandom_range(0, 1);
        rs_in          = 5'($urandom_range(0, 3));
        rt_in          = 5'($urandom_range(0, 3));
        rd_in          = 5'($urandom);
        sa_in          = 5'($urandom);
        ctrl_in        = 18'($urandom);
        data_a_in      = $urandom;
        data_b_in      = $urandom;
        sign_extend_in = $urandom;
        jump_dest_in   = 11'($urandom);
    endtask

    initial begin
        m_ex = '{default: '0};
        m_bubbles = 0;
        @(posedge clock);
        #1;

        // Reset with every input nonzero
        set_instr(5'd9, 5'd9, 1, 1, 18'h3FFFF);
        reset = 1; stall_in = 1; flush_in = 1;
        step();

        // Pass-through: RegWrite=1, ALUOp=2
        set_instr(5'd1, 5'd2, 1, 1, 18'h00108);
        data_a_in = 32'h12345678;
        step();

        // Load-use: lw rt=5 then add rs=5, then add proceeds
        set_instr(5'd0, 5'd5, 1, 0, 18'h00018);
        step();
        set_instr(5'd5, 5'd6, 1, 1, 18'h00108);
        step();
        step();

        // Load to $0 never stalls
        set_instr(5'd0, 5'd0, 1, 0, 18'h00018);
        step();
        set_instr(5'd0, 5'd4, 1, 1, 18'h00108);
        step();

        // Stall dominates flush for three edges, then flush bubbles
        for (int i = 0; i < 3; i++) begin
            set_instr(5'd1, 5'd1, 1, 1, 18'h00108);
            stall_in = 1; flush_in = 1;
            step();
        end
        set_instr(5'd1, 5'd1, 1, 1, 18'h00108);
        flush_in = 1;
        step();

        // Five flushes after reset: narrow counter sticks at 3
        set_instr(5'd1, 5'd1, 1, 1, 18'h00108);
        reset = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            set_instr(5'd1, 5'd1, 1, 1, 18'h00108);
            flush_in = 1;
            step();
        end

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
